// File: rtl/bitcoin_hash_multi.sv
// bitcoin_hash_multi
// ------------------
// Double-SHA-256 nonce-search engine. It reads a 20-word block header from a
// single-port memory and compresses header words 0..15 once to form the
// midstate. For every nonce n in 0..NUM_NONCES-1 it then computes
// SHA-256(SHA-256(header with word 19 = n)) and writes word 0 of the final
// digest to output_addr+n. One round core, which does one round per cycle,
// is shared by all compressions.
//
// Optional feature macro: BTC_EARLY_EXIT_EN
//   When it is defined, the block gains input target and outputs found and
//   found_nonce. The search stops at the first digest word 0 below target.
//
// Parameters:
//   NUM_NONCES  number of nonces searched (1..256)
//   ADDR_W      memory address width
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               job request, sampled only in IDLE
//   message_addr        base address of the 20 header words
//   output_addr         base address of the NUM_NONCES result words
//   done                one-cycle pulse at job end
//   mem_clk             copy of clk for the memory
//   mem_we, mem_addr    write strobe and address (both registered)
//   mem_write_data      write data (registered)
//   mem_read_data       read data, valid the cycle after mem_addr
//   target              (early exit only) search threshold, latched at start
//   found, found_nonce  (early exit only) hit flag and the nonce that hit
module bitcoin_hash_multi #(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
`ifdef BTC_EARLY_EXIT_EN
  input  logic [31:0]       target,
  output logic              found,
  output logic [7:0]        found_nonce,
`endif
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  // P1 = midstate, P2 = first hash of a nonce block, P3 = second hash.
  typedef enum logic [1:0] {
    P1 = 2'd0,
    P2 = 2'd1,
    P3 = 2'd2
  } pass_t;

  localparam logic [8:0] LAST_NONCE = 9'(NUM_NONCES - 1);

  // SHA-256 round constants
  function automatic logic [31:0] k_const(input logic [5:0] t);
    case (t)
      6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7;  6'd63: return 32'hc67178f2;
      default: return 32'h00000000;
    endcase
  endfunction

  // SHA-256 initial hash value
  function automatic logic [31:0] sha_iv(input logic [2:0] i);
    case (i)
      3'd0: return 32'h6a09e667;
      3'd1: return 32'hbb67ae85;
      3'd2: return 32'h3c6ef372;
      3'd3: return 32'ha54ff53a;
      3'd4: return 32'h510e527f;
      3'd5: return 32'h9b05688c;
      3'd6: return 32'h1f83d9ab;
      3'd7: return 32'h5be0cd19;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  state_t            state_r;
  pass_t             pass_r;
  logic [6:0]        cnt_r;
  logic [8:0]        nonce_r;
  logic [ADDR_W-1:0] out_base_r;
  logic [31:0]       hw_r  [20];
  logic [31:0]       mid_r [8];
  logic [31:0]       dig_r [8];
  logic [31:0]       w_r   [16];
  logic [31:0]       a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
`ifdef BTC_EARLY_EXIT_EN
  logic [31:0]       target_r;
  logic              hit_r;
`endif

  logic [31:0] blk_s  [16];
  logic [31:0] base_s [8];
  logic [31:0] var_s  [8];
  logic [31:0] sum_s  [8];
  logic [31:0] t1_s, t2_s, w_new_s;

  assign mem_clk = clk;

  // Message block presented to the round core at LOAD, selected by pass
  always_comb begin
    for (int i = 0; i < 16; i++) blk_s[i] = 32'h00000000;
    case (pass_r)
      P1: begin
        for (int i = 0; i < 16; i++) blk_s[i] = hw_r[i];
      end
      P2: begin
        blk_s[0]  = hw_r[16];
        blk_s[1]  = hw_r[17];
        blk_s[2]  = hw_r[18];
        blk_s[3]  = {23'd0, nonce_r};
        blk_s[4]  = 32'h80000000;
        blk_s[15] = 32'h00000280;  // 640-bit message length
      end
      P3: begin
        for (int i = 0; i < 8; i++) blk_s[i] = dig_r[i];
        blk_s[8]  = 32'h80000000;
        blk_s[15] = 32'h00000100;  // 256-bit message length
      end
      default: begin
        for (int i = 0; i < 16; i++) blk_s[i] = 32'h00000000;
      end
    endcase
  end

  // Base hash, working variables and their per-word sums for FINAL
  always_comb begin
    var_s = '{a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r};
    for (int i = 0; i < 8; i++) begin
      base_s[i] = (pass_r == P2) ? mid_r[i] : sha_iv(3'(i));
      sum_s[i]  = base_s[i] + var_s[i];
    end
  end

  // One SHA-256 round plus the next schedule word from the sliding window
  always_comb begin
    t1_s    = h_r + big_sigma1(e_r) + ((e_r & f_r) ^ (~e_r & g_r))
              + k_const(cnt_r[5:0]) + w_r[0];
    t2_s    = big_sigma0(a_r) + ((a_r & b_r) ^ (a_r & c_r) ^ (b_r & c_r));
    w_new_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
  end

  // Control FSM, datapath registers and registered memory-bus outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      pass_r         <= P1;
      cnt_r          <= 7'd0;
      nonce_r        <= 9'd0;
      out_base_r     <= '0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= 32'h00000000;
      {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r} <= '0;
      for (int i = 0; i < 20; i++) hw_r[i] <= 32'h00000000;
      for (int i = 0; i < 16; i++) w_r[i] <= 32'h00000000;
      for (int i = 0; i < 8; i++) begin
        mid_r[i] <= 32'h00000000;
        dig_r[i] <= 32'h00000000;
      end
`ifdef BTC_EARLY_EXIT_EN
      target_r    <= 32'h00000000;
      hit_r       <= 1'b0;
      found       <= 1'b0;
      found_nonce <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done   <= 1'b0;
          mem_we <= 1'b0;
          if (start) begin
            out_base_r <= output_addr;
            mem_addr   <= message_addr;
            cnt_r      <= 7'd0;
            nonce_r    <= 9'd0;
            pass_r     <= P1;
`ifdef BTC_EARLY_EXIT_EN
            target_r    <= target;
            found       <= 1'b0;
            found_nonce <= 8'd0;
`endif
            state_r    <= READ;
          end
        end
        READ: begin
          // Data for the address shown at count k arrives at count k+1.
          if (cnt_r != 7'd0) hw_r[cnt_r[4:0] - 5'd1] <= mem_read_data;
          if (cnt_r < 7'd19) mem_addr <= mem_addr + ADDR_W'(1);
          if (cnt_r == 7'd20) begin
            cnt_r   <= 7'd0;
            state_r <= LOAD;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        LOAD: begin
          {a_r, b_r, c_r, d_r} <= {base_s[0], base_s[1], base_s[2], base_s[3]};
          {e_r, f_r, g_r, h_r} <= {base_s[4], base_s[5], base_s[6], base_s[7]};
          for (int i = 0; i < 16; i++) w_r[i] <= blk_s[i];
          cnt_r   <= 7'd0;
          state_r <= ROUND;
        end
        ROUND: begin
          a_r <= t1_s + t2_s;
          b_r <= a_r;
          c_r <= b_r;
          d_r <= c_r;
          e_r <= d_r + t1_s;
          f_r <= e_r;
          g_r <= f_r;
          h_r <= g_r;
          // w_r[0] always holds W[t] for the current round.
          for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
          w_r[15] <= w_new_s;
          if (cnt_r == 7'd63) begin
            cnt_r   <= 7'd0;
            state_r <= FINAL;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        FINAL: begin
          case (pass_r)
            P1: begin
              for (int i = 0; i < 8; i++) mid_r[i] <= sum_s[i];
              pass_r  <= P2;
              state_r <= LOAD;
            end
            P2: begin
              for (int i = 0; i < 8; i++) dig_r[i] <= sum_s[i];
              pass_r  <= P3;
              state_r <= LOAD;
            end
            P3: begin
              mem_we         <= 1'b1;
              mem_addr       <= out_base_r + ADDR_W'(nonce_r);
              mem_write_data <= sum_s[0];
`ifdef BTC_EARLY_EXIT_EN
              hit_r          <= (sum_s[0] < target_r);
`endif
              state_r        <= WRITE;
            end
            default: begin
              state_r <= IDLE;
            end
          endcase
        end
        WRITE: begin
          mem_we  <= 1'b0;
          nonce_r <= nonce_r + 9'd1;
          pass_r  <= P2;
`ifdef BTC_EARLY_EXIT_EN
          if (hit_r) begin
            found       <= 1'b1;
            found_nonce <= nonce_r[7:0];
            done        <= 1'b1;
            state_r     <= DONE;
          end else
`endif
          if (nonce_r == LAST_NONCE) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= LOAD;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_hash_multi.sv
// tb_bitcoin_hash_multi
// ---------------------
// Directed self-checking bench for bitcoin_hash_multi. Instance u_a uses the
// default 16 nonces, instance u_b is built with NUM_NONCES=1. Expected digest
// words come from an independent SHA-256 reference function in this file,
// itself anchored against the published "abc" and empty-string digests.
module tb_bitcoin_hash_multi;

  typedef logic [7:0][31:0]  st_t;
  typedef logic [15:0][31:0] blk_t;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        a_start, a_done, a_mclk, a_we;
  logic [15:0] a_msg, a_out, a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_start, b_done, b_mclk, b_we;
  logic [15:0] b_msg, b_out, b_addr;
  logic [31:0] b_wdata, b_rdata;
`ifdef BTC_EARLY_EXIT_EN
  logic [31:0] a_target, b_target;
  logic        a_found, b_found;
  logic [7:0]  a_fnonce, b_fnonce;
`endif

  bitcoin_hash_multi #(.NUM_NONCES(16), .ADDR_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .start(a_start),
    .message_addr(a_msg), .output_addr(a_out),
`ifdef BTC_EARLY_EXIT_EN
    .target(a_target), .found(a_found), .found_nonce(a_fnonce),
`endif
    .done(a_done), .mem_clk(a_mclk), .mem_we(a_we), .mem_addr(a_addr),
    .mem_write_data(a_wdata), .mem_read_data(a_rdata));

  bitcoin_hash_multi #(.NUM_NONCES(1), .ADDR_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .start(b_start),
    .message_addr(b_msg), .output_addr(b_out),
`ifdef BTC_EARLY_EXIT_EN
    .target(b_target), .found(b_found), .found_nonce(b_fnonce),
`endif
    .done(b_done), .mem_clk(b_mclk), .mem_we(b_we), .mem_addr(b_addr),
    .mem_write_data(b_wdata), .mem_read_data(b_rdata));

  // Shared read-only header memory with one-cycle read latency per port
  logic [31:0] mem [65536];
  always @(posedge clk) begin
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  // Write and done logs, stamped with the cycle counter
  int          a_wr_cyc[$], a_done_cyc[$], b_wr_cyc[$], b_done_cyc[$];
  logic [15:0] a_wr_addr[$], b_wr_addr[$];
  logic [31:0] a_wr_data[$], b_wr_data[$];
  always @(negedge clk) begin
    if (a_we === 1'b1) begin a_wr_cyc.push_back(gcyc); a_wr_addr.push_back(a_addr); a_wr_data.push_back(a_wdata); end
    if (b_we === 1'b1) begin b_wr_cyc.push_back(gcyc); b_wr_addr.push_back(b_addr); b_wr_data.push_back(b_wdata); end
    if (a_done === 1'b1) a_done_cyc.push_back(gcyc);
    if (b_done === 1'b1) b_done_cyc.push_back(gcyc);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] hdr [20];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic st_t iv_state();
    st_t r;
    r[0] = 32'h6a09e667; r[1] = 32'hbb67ae85; r[2] = 32'h3c6ef372; r[3] = 32'ha54ff53a;
    r[4] = 32'h510e527f; r[5] = 32'h9b05688c; r[6] = 32'h1f83d9ab; r[7] = 32'h5be0cd19;
    return r;
  endfunction

  // Reference compression with the full 64-entry message schedule
  function automatic st_t compress(input st_t h, input blk_t m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    st_t r;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
           + ((v[4] & v[5]) | (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) | (v[2] & (v[0] | v[1])));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  // Expected result word for nonce n over the bench header
  function automatic logic [31:0] expect_word(input int n);
    blk_t b;
    st_t  mid, d2, d3;
    for (int i = 0; i < 16; i++) b[i] = hdr[i];
    mid = compress(iv_state(), b);
    b = '0;
    b[0] = hdr[16]; b[1] = hdr[17]; b[2] = hdr[18]; b[3] = 32'(n);
    b[4] = 32'h80000000; b[15] = 32'h00000280;
    d2 = compress(mid, b);
    b = '0;
    for (int i = 0; i < 8; i++) b[i] = d2[i];
    b[8] = 32'h80000000; b[15] = 32'h00000100;
    d3 = compress(iv_state(), b);
    return d3[0];
  endfunction

  task automatic clear_logs();
    a_wr_cyc.delete(); a_wr_addr.delete(); a_wr_data.delete(); a_done_cyc.delete();
    b_wr_cyc.delete(); b_wr_addr.delete(); b_wr_data.delete(); b_done_cyc.delete();
  endtask

  // Full 16-nonce job on u_a at message 0x0000 / output 0x0020
  task automatic run_a_full(input string tag);
    int t0;
    clear_logs();
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1; t0 = gcyc; a_start = 1'b0;
    for (int i = 0; i < 2400 && a_done_cyc.size() == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check({tag, "_done_count"}, 32'(a_done_cyc.size()), 32'd1);
    if (a_done_cyc.size() > 0) check({tag, "_done_cycle"}, 32'(a_done_cyc[0] - t0 + 1), 32'd2216);
    check({tag, "_write_count"}, 32'(a_wr_addr.size()), 32'd16);
    for (int k = 0; k < a_wr_addr.size() && k < 16; k++) begin
      check($sformatf("%s_addr%0d", tag, k), {16'h0000, a_wr_addr[k]}, 32'h00000020 + 32'(k));
      check($sformatf("%s_data%0d", tag, k), a_wr_data[k], expect_word(k));
      check($sformatf("%s_wcyc%0d", tag, k), 32'(a_wr_cyc[k] - t0 + 1), 32'(220 + 133 * k));
    end
  endtask

  initial begin
    blk_t b;
    st_t  d;
    int   t0, bad;

    reset_n = 1'b0;
    a_start = 1'b0; a_msg = 16'h0000; a_out = 16'h0020;
    b_start = 1'b0; b_msg = 16'hFFF0; b_out = 16'hFFFF;
`ifdef BTC_EARLY_EXIT_EN
    a_target = 32'h00000000; b_target = 32'h00000000;
`endif
    for (int i = 0; i < 20; i++) hdr[i] = 32'h12345678 ^ (32'(i) * 32'h9e3779b9);
    for (int i = 0; i < 20; i++) mem[i] = hdr[i];

    // Reference model anchored to published digests
    b = '0; b[0] = 32'h61626380; b[15] = 32'h00000018;
    d = compress(iv_state(), b);
    check("model_abc_w0", d[0], 32'hba7816bf);
    check("model_abc_w7", d[7], 32'hf20015ad);
    b = '0; b[0] = 32'h80000000;
    d = compress(iv_state(), b);
    check("model_empty_w0", d[0], 32'he3b0c442);
    check("model_empty_w7", d[7], 32'h7852b855);

    // Reset values, then a quiet idle with start low
    @(posedge clk); @(negedge clk);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_we", {31'd0, a_we}, 32'd0);
    check("rst_addr", {16'h0000, a_addr}, 32'd0);
    check("rst_wdata", a_wdata, 32'd0);
    check("rst_mem_clk", {31'd0, a_mclk}, {31'd0, clk});
    @(posedge clk); @(negedge clk); reset_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_we !== 1'b0 || a_addr !== 16'h0000) bad++;
      if (b_done !== 1'b0 || b_we !== 1'b0 || b_addr !== 16'h0000) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Default 16-nonce run
    run_a_full("full");
`ifdef BTC_EARLY_EXIT_EN
    check("full_found", {31'd0, a_found}, 32'd0);
`endif

    // Reset during P2(5): no further writes, outputs back to reset values
    clear_logs();
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1; t0 = gcyc; a_start = 1'b0;
    repeat (780) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_we", {31'd0, a_we}, 32'd0);
    check("midrst_addr", {16'h0000, a_addr}, 32'd0);
    check("midrst_wdata", a_wdata, 32'd0);
    check("midrst_done", {31'd0, a_done}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_writes", 32'(a_wr_addr.size()), 32'd5);
    check("midrst_no_done", 32'(a_done_cyc.size()), 32'd0);
    run_a_full("after_rst");

    // NUM_NONCES=1, header wraps past 0xFFFF, result at 0xFFFF
    for (int i = 0; i < 20; i++) mem[(32'hFFF0 + i) & 32'hFFFF] = hdr[i];
    clear_logs();
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1; t0 = gcyc; b_start = 1'b0;
    for (int i = 0; i < 400 && b_done_cyc.size() == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("one_done_count", 32'(b_done_cyc.size()), 32'd1);
    if (b_done_cyc.size() > 0) check("one_done_cycle", 32'(b_done_cyc[0] - t0 + 1), 32'd221);
    check("one_write_count", 32'(b_wr_addr.size()), 32'd1);
    if (b_wr_addr.size() > 0) begin
      check("one_addr", {16'h0000, b_wr_addr[0]}, 32'h0000FFFF);
      check("one_data", b_wr_data[0], expect_word(0));
      check("one_wcyc", 32'(b_wr_cyc[0] - t0 + 1), 32'd220);
    end

    // start held high: jobs run back to back, second starts after IDLE
    clear_logs();
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1; t0 = gcyc;
    for (int i = 0; i < 900 && b_done_cyc.size() < 2; i++) @(negedge clk);
    b_start = 1'b0;
    repeat (300) @(negedge clk);
    check("held_done_count", 32'(b_done_cyc.size()), 32'd2);
    check("held_write_count", 32'(b_wr_addr.size()), 32'd2);
    if (b_done_cyc.size() == 2 && b_wr_addr.size() == 2) begin
      check("held_done0", 32'(b_done_cyc[0] - t0 + 1), 32'd221);
      check("held_done1", 32'(b_done_cyc[1] - t0 + 1), 32'd443);
      check("held_wcyc0", 32'(b_wr_cyc[0] - t0 + 1), 32'd220);
      check("held_wcyc1", 32'(b_wr_cyc[1] - t0 + 1), 32'd442);
      check("held_data1", b_wr_data[1], expect_word(0));
    end

`ifdef BTC_EARLY_EXIT_EN
    // Early exit on the first nonce with an all-ones target
    for (int i = 0; i < 20; i++) mem[i] = hdr[i];
    a_target = 32'hFFFFFFFF;
    clear_logs();
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1; t0 = gcyc; a_start = 1'b0;
    for (int i = 0; i < 400 && a_done_cyc.size() == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("early_write_count", 32'(a_wr_addr.size()), 32'd1);
    if (a_done_cyc.size() > 0) check("early_done_cycle", 32'(a_done_cyc[0] - t0 + 1), 32'd221);
    check("early_found", {31'd0, a_found}, 32'd1);
    check("early_found_nonce", {24'd0, a_fnonce}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
